lock_key_loader: RTL

//  Key-provisioning end of the logic-locking key interface: receives a serial key frame from the

---
 rtl/lock_key_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lock_key_loader.sv
// Serial key loader for a logic-locked core: receives a parity-protected key frame and drives the key bus.
// Optional zeroize input port and clear path are enabled by defining LOCK_KEY_LOADER_ZEROIZE_EN.
module lock_key_loader #(
  parameter int              KEY_W    = 3,
  parameter logic [KEY_W-1:0] KEY_RST = '0,
  parameter int              TIMEOUT  = 16,
  parameter int              MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_sdi,
  input  logic             key_sv,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_err,
  output logic             locked_out,
  output logic             busy
`ifdef LOCK_KEY_LOADER_ZEROIZE_EN
  ,
  input  logic             zeroize
`endif
);

  localparam int CNT_W  = $clog2(KEY_W + 2);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(KEY_W);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_VALID,
    S_ERROR,
    S_LOCKOUT
  } state_e;

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KEY_W:0]    shadow_q, shadow_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic              key_err_q, key_err_d;
  logic [FAIL_W-1:0] fail_inc;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    fail_cnt_d = fail_cnt_q;
    key_err_d  = key_err_q;
    fail_inc   = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + FAIL_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d   = S_SHIFT;
          key_err_d = 1'b0;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end
      S_SHIFT: begin
        if (key_sv) begin
          shadow_d  = {shadow_q[KEY_W-1:0], key_sdi};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          timer_d   = '0;
          if (bit_cnt_q == LAST_BIT) state_d = S_CHECK;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_q == TMR_LAST) state_d = S_ERROR;
        end
      end
      // Odd parity over key plus parity bit is the only acceptance rule.
      S_CHECK: begin
        if (^shadow_q) begin
          state_d    = S_VALID;
          key_d      = shadow_q[KEY_W:1];
          fail_cnt_d = '0;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_VALID: begin
        if (load_start) begin
          state_d   = S_SHIFT;
          key_d     = KEY_RST;
          key_err_d = 1'b0;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end
      S_ERROR: begin
        key_err_d  = 1'b1;
        fail_cnt_d = fail_inc;
        state_d    = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        state_d = S_LOCKOUT;
      end
      default: begin
        state_d = S_IDLE;
        key_d   = KEY_RST;
      end
    endcase

`ifdef LOCK_KEY_LOADER_ZEROIZE_EN
    // Zeroize wipes key material but keeps the failure history intact.
    if (zeroize && (state_q != S_LOCKOUT)) begin
      state_d    = S_IDLE;
      key_d      = KEY_RST;
      shadow_d   = '0;
      bit_cnt_d  = '0;
      timer_d    = '0;
      key_err_d  = key_err_q;
      fail_cnt_d = fail_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= KEY_RST;
      shadow_q   <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      shadow_q   <= shadow_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      fail_cnt_q <= fail_cnt_d;
      key_err_q  <= key_err_d;
    end
  end

  assign key        = key_q;
  assign key_valid  = (state_q == S_VALID);
  assign key_err    = key_err_q;
  assign locked_out = (state_q == S_LOCKOUT);
  assign busy       = (state_q == S_SHIFT) || (state_q == S_CHECK);

endmodule
